vga_display_sched: RTL
======================

# vga_display_sched

Frame-synchronous display scheduler between the timekeeping/alarm logic and the VGA pixel generator. It snapshots the clock and alarm BCD values only at the start of vertical sync, so the pixel generator never renders a half-updated time. It runs the display mode state machine (normal, edit-time, edit-alarm, ringing) and produces per-digit blank masks for cursor and alarm blinking, timed in whole frames.

## Interface
- BLINK_FRAMES, 30, frames per blink half-period (30 gives 1 Hz blink at 60 Hz frames); legal range 1..255.
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- vsync  in  1  active-low vertical sync from vga_controller, synchronous to clk_100MHz.
- clock_val  in  16  live time {hr_10s, hr_1s, min_10s, min_1s}, 4-bit BCD each.
- alarm_val  in  16  live alarm setting, same packing.
- set_time  in  1  level; requests time-edit mode.
- set_alarm  in  1  level; requests alarm-edit mode.
- field_next  in  1  single-cycle pulse; toggles the edited field.
- alarm_ring  in  1  level; alarm is sounding.
- disp_clock  out  16  frame-latched clock_val, to pixel generator.
- disp_alarm  out  16  frame-latched alarm_val.
- clock_blank  out  4  per-digit suppress for the clock (bit0 = min_1s, bit3 = hr_10s; 1 = blank).
- alarm_blank  out  4  per-digit suppress for the alarm, same ordering.
- mode  out  2  00 NORMAL, 01 EDIT_TIME, 10 EDIT_ALARM, 11 RING.
- edit_field  out  1  0 = minutes, 1 = hours.
- frame_tick  out  1  one-cycle pulse marking a frame boundary.

## Operation
- Frame detect: register vsync_d (reset 0). The detect condition is vsync_d=1 and vsync=0. A registered frame_tick fires the following cycle. A vsync held low through reset release produces no tick.
- On frame_tick:
  - Latch disp_clock←clock_val and disp_alarm←alarm_val, using the values sampled in the detect cycle.
  - Register both blank masks.
  - Advance the blink counter (0..BLINK_FRAMES-1). On wrap, the counter returns to 0 and blink_phase toggles (1 = visible).
- Mode FSM is evaluated every cycle, not frame-gated. Next state:
  - set_time=1, set_alarm=0 → EDIT_TIME.
  - set_alarm=1, set_time=0 → EDIT_ALARM.
  - Both high → hold the current state.
  - Neither high → RING if alarm_ring=1, otherwise NORMAL.
  - Edit modes take priority over RING.
- On any mode change: edit_field←0, blink counter←0, blink_phase←1.
- field_next in an EDIT state toggles edit_field and resets the counter to 0 and blink_phase to 1. field_next is ignored in NORMAL and RING.
- Blank mask rules, computed from the mode, edit_field and blink_phase present in the detect cycle (pre-update):
  - NORMAL: both masks 0000.
  - EDIT_TIME: clock_blank = phase ? 0000 : (field ? 1100 : 0011); alarm_blank = 0000.
  - EDIT_ALARM: the same rule applied to alarm_blank; clock_blank = 0000.
  - RING: clock_blank = phase ? 0000 : 1111; alarm_blank = 0000.
- BCD values pass through unchanged; no validity checking.

## Timing
- Reset values: disp_clock=0, disp_alarm=0, clock_blank=0, alarm_blank=0, mode=00, edit_field=0, frame_tick=0, counter=0, blink_phase=1, vsync_d=0.
- Latency:
  - vsync first sampled low in cycle N → frame_tick high in cycle N+1.
  - disp_* and *_blank change at the same edge as frame_tick rises.
  - They are stable until the next tick (one 640x480 frame ≈ 1.67M cycles).
- mode and edit_field update one cycle after the input change. The masks reflect the change only at the next frame_tick.
- Mode change or field toggle in the same cycle as detect:
  - The counter/phase reset wins over the advance.
  - The masks use the pre-change state.
- Reset mid-frame clears everything immediately (asynchronous). The next tick requires a fresh vsync falling edge.
- vsync low for multiple cycles produces exactly one tick.

## Test plan
- Reset, then one vsync 1→0 edge with clock_val=16'h0830 → frame_tick pulses exactly one cycle, one cycle after the edge; disp_clock=16'h0830; clock_val changed mid-frame to 16'h0831 leaves disp_clock unchanged until the next tick.
- BLINK_FRAMES=2, set_time=1 held, ten frames → mode=01; clock_blank sequence 0000,0000,0011,0011,0000,...; alarm_blank always 0000.
- BLINK_FRAMES=2, EDIT_ALARM, field_next pulse mid-frame → edit_field=1 next cycle, blink restarts visible, alarm_blank then alternates 0000/1100 on 2-frame boundaries; field_next in NORMAL → no change.
- alarm_ring=1 with no set inputs → mode=11, clock_blank toggles 0000/1111; assert set_time → mode=01 next cycle; set_time and set_alarm both high → mode holds.
- vsync held low across reset release → no frame_tick; assert reset mid-EDIT_TIME with clock_blank=0011 → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/vga_display_sched.sv
// Frame-synchronous display scheduler: snapshots clock/alarm BCD at vsync falling edge,
// runs the display mode FSM and produces per-digit blink masks timed in whole frames.
module vga_display_sched #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        vsync,
    input  logic [15:0] clock_val,
    input  logic [15:0] alarm_val,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        field_next,
    input  logic        alarm_ring,
    output logic [15:0] disp_clock,
    output logic [15:0] disp_alarm,
    output logic [3:0]  clock_blank,
    output logic [3:0]  alarm_blank,
    output logic [1:0]  mode,
    output logic        edit_field,
    output logic        frame_tick
);

    localparam int unsigned BCD_W = 16;
    localparam int unsigned DIG_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [DIG_W-1:0] MASK_NONE  = 4'b0000;
    localparam logic [DIG_W-1:0] MASK_MINS  = 4'b0011;
    localparam logic [DIG_W-1:0] MASK_HOURS = 4'b1100;
    localparam logic [DIG_W-1:0] MASK_ALL   = 4'b1111;

    typedef enum logic [1:0] {
        MODE_NORMAL     = 2'b00,
        MODE_EDIT_TIME  = 2'b01,
        MODE_EDIT_ALARM = 2'b10,
        MODE_RING       = 2'b11
    } mode_e;

    mode_e              mode_q, mode_d;
    logic               vsync_q;
    logic               tick_q;
    logic [BCD_W-1:0]   disp_clock_q, disp_alarm_q;
    logic [DIG_W-1:0]   clock_blank_q, alarm_blank_q;
    logic [DIG_W-1:0]   clock_blank_d, alarm_blank_d;
    logic               field_q, field_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;

    logic               detect_c;
    logic               mode_chg_c;
    logic               in_edit_c;
    logic [DIG_W-1:0]   edit_mask_c;

    // Falling edge of vsync; vsync_q resets low so a vsync held low through reset never fires.
    assign detect_c = vsync_q & ~vsync;

    // Mode transition: edits beat ring, both edit requests together freeze the mode.
    always_comb begin
        mode_d = mode_q;
        unique case ({set_time, set_alarm})
            2'b10:   mode_d = MODE_EDIT_TIME;
            2'b01:   mode_d = MODE_EDIT_ALARM;
            2'b11:   mode_d = mode_q;
            default: mode_d = alarm_ring ? MODE_RING : MODE_NORMAL;
        endcase
    end

    assign mode_chg_c = (mode_d != mode_q);
    assign in_edit_c  = (mode_q == MODE_EDIT_TIME) || (mode_q == MODE_EDIT_ALARM);

    // Field and blink timebase; a mode change or field toggle restarts blink visible.
    always_comb begin
        field_d = field_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (mode_chg_c) begin
            field_d = 1'b0;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (field_next && in_edit_c) begin
            field_d = ~field_q;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (detect_c) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Blank masks from the pre-update mode/field/phase.
    always_comb begin
        edit_mask_c   = phase_q ? MASK_NONE : (field_q ? MASK_HOURS : MASK_MINS);
        clock_blank_d = MASK_NONE;
        alarm_blank_d = MASK_NONE;
        unique case (mode_q)
            MODE_EDIT_TIME:  clock_blank_d = edit_mask_c;
            MODE_EDIT_ALARM: alarm_blank_d = edit_mask_c;
            MODE_RING:       clock_blank_d = phase_q ? MASK_NONE : MASK_ALL;
            default: begin
                clock_blank_d = MASK_NONE;
                alarm_blank_d = MASK_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            tick_q        <= 1'b0;
            mode_q        <= MODE_NORMAL;
            field_q       <= 1'b0;
            cnt_q         <= '0;
            phase_q       <= 1'b1;
            disp_clock_q  <= '0;
            disp_alarm_q  <= '0;
            clock_blank_q <= '0;
            alarm_blank_q <= '0;
        end else begin
            vsync_q <= vsync;
            tick_q  <= detect_c;
            mode_q  <= mode_d;
            field_q <= field_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            if (detect_c) begin
                disp_clock_q  <= clock_val;
                disp_alarm_q  <= alarm_val;
                clock_blank_q <= clock_blank_d;
                alarm_blank_q <= alarm_blank_d;
            end
        end
    end

    assign disp_clock  = disp_clock_q;
    assign disp_alarm  = disp_alarm_q;
    assign clock_blank = clock_blank_q;
    assign alarm_blank = alarm_blank_q;
    assign mode        = mode_q;
    assign edit_field  = field_q;
    assign frame_tick  = tick_q;

endmodule
